// File: rtl/ins_stream_pkg.sv
// rtl/ins_stream_pkg.sv - shared types and default sizing for the streaming insertion sorter
package ins_stream_pkg;

    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W     = $clog2(DEPTH_DEF + 1);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/ins_stream_cell.sv
// rtl/ins_stream_cell.sv - one sorter slot: register plus compare/select against its neighbours
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   insert       a new word is being inserted this cycle
//   shift        the array shifts up one slot this cycle (drain pop)
//   occ          this slot currently holds a valid word
//   new_data     the word being inserted
//   upper_data   contents of the slot above (index - 1)
//   upper_disp   the slot above is being displaced by the new word
//   lower_data   contents of the slot below (index + 1)
//   data         this slot's contents
//   disp         the new word displaces this slot's word
//
// Build option INS_STREAM_ASCEND_EN: displacement on strictly-less (ascending order).
module ins_stream_cell
    import ins_stream_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         insert,
    input  logic         shift,
    input  logic         occ,
    input  logic [W-1:0] new_data,
    input  logic [W-1:0] upper_data,
    input  logic         upper_disp,
    input  logic [W-1:0] lower_data,
    output logic [W-1:0] data,
    output logic         disp
);

    // Strict comparison keeps equal words in arrival order: a new equal
    // word never displaces, so it lands below the existing ones.
`ifdef INS_STREAM_ASCEND_EN
    assign disp = occ && (new_data < data);
`else
    assign disp = occ && (new_data > data);
`endif

    // On insert, a displaced slot (or the first free slot) takes either the
    // word pushed down from above or, at the insertion point, the new word.
    // Free slots past the insertion point also load but are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (insert && (disp || !occ)) begin
            data <= upper_disp ? upper_data : new_data;
        end else if (shift) begin
            data <= lower_data;
        end
    end

endmodule

// File: rtl/ins_stream.sv
// rtl/ins_stream.sv - streaming insertion sorter: load a block word-serially, drain it sorted
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_valid, s_ready, s_data,
//   s_last                       input word stream (block closes on s_last or when full)
//   m_valid, m_ready, m_data,
//   m_last                       sorted output stream (m_last on the final word)
//
// Build option INS_STREAM_ASCEND_EN: ascending output instead of descending.
module ins_stream
    import ins_stream_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        state, state_d;
    logic [CW-1:0] count, count_d;

    logic          accept;
    logic          pop;

    logic [W-1:0]  slot [DEPTH];
    logic          disp [DEPTH];

    // s_ready is only high in LOAD and m_valid only in DRAIN, so each
    // handshake already implies its state.
    assign accept = s_valid && s_ready;
    assign pop    = m_valid && m_ready;
    assign m_data = slot[0];

    always_comb begin
        state_d = state;
        count_d = count;
        case (state)
            LOAD: begin
                if (accept) begin
                    count_d = count + CW'(1);
                    if (s_last || (count == CW'(DEPTH - 1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    count_d = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Handshake outputs are registered from the next-state values so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            count   <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            s_ready <= (state_d == LOAD);
            m_valid <= (state_d == DRAIN);
            m_last  <= (state_d == DRAIN) && (count_d == CW'(1));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [W-1:0] up_data;
        logic         up_disp;
        logic [W-1:0] lo_data;

        if (i == 0) begin : g_top
            assign up_data = '0;
            assign up_disp = 1'b0;
        end else begin : g_mid
            assign up_data = slot[i-1];
            assign up_disp = disp[i-1];
        end

        if (i == DEPTH - 1) begin : g_bot
            assign lo_data = '0;
        end else begin : g_low
            assign lo_data = slot[i+1];
        end

        ins_stream_cell #(
            .W (W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .insert     (accept),
            .shift      (pop),
            .occ        (count > CW'(i)),
            .new_data   (s_data),
            .upper_data (up_data),
            .upper_disp (up_disp),
            .lower_data (lo_data),
            .data       (slot[i]),
            .disp       (disp[i])
        );
    end

endmodule

// File: tb/tb_ins_stream.sv
// tb/tb_ins_stream.sv - scoreboard bench for ins_stream with directed blocks
module tb_ins_stream;

    localparam int W     = 32;
    localparam int DEPTH = 8;

`ifdef INS_STREAM_ASCEND_EN
    localparam bit ASC = 1'b1;
`else
    localparam bit ASC = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;

    ins_stream #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic toggle_mode = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (toggle_mode) m_ready = ~m_ready;
        else             m_ready = 1'b1;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks
    // that a stalled word is held unchanged.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_d;
    logic         prev_l;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid) begin
                check("hold_data", m_data, prev_d);
                check("hold_last", W'(m_last), W'(prev_l));
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output actual=%0d required=none", m_data);
                end else begin
                    mon_e = q.pop_front();
                    check("out_data", m_data, mon_e.d);
                    check("out_last", W'(m_last), W'(mon_e.l));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    // dexp holds the hand-computed descending order; ascending builds read it backwards.
    task automatic expect_block(input logic [W-1:0] dexp[8], input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = ASC ? dexp[n-1-i] : dexp[i];
            e.l = (i == n - 1);
            q.push_back(e);
        end
    endtask

    task automatic send_block(input logic [W-1:0] din[8], input int n, input logic use_last);
        int guard;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = din[i];
            s_last  = use_last && (i == n - 1);
            guard   = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!s_ready && guard < 100);
            if (!s_ready) begin
                fail_now("s_ready_wait");
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("first_valid_latency", W'(m_valid), W'(1));
        check("s_ready_in_drain", W'(s_ready), W'(0));
    endtask

    task automatic wait_drain();
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 200) begin
            if (m_valid && m_ready && m_last) done = 1'b1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        if (!done) begin
            fail_now("drain_wait");
        end else begin
            @(negedge clk);
            check("turnaround_s_ready", W'(s_ready), W'(1));
            check("turnaround_m_valid", W'(m_valid), W'(0));
        end
        check("scoreboard_empty", W'(q.size()), W'(0));
    endtask

    initial begin
        logic [W-1:0] t1_in [8];
        logic [W-1:0] t1_ex [8];
        logic [W-1:0] t2_in [8];
        logic [W-1:0] t2_ex [8];
        logic [W-1:0] t3_in [8];
        logic [W-1:0] t3_ex [8];
        logic [W-1:0] t4_in [8];
        logic [W-1:0] t4_ex [8];
        logic [W-1:0] t5_in [8];
        logic [W-1:0] t5_ex [8];
        logic [W-1:0] t6_in [8];
        logic [W-1:0] t6_ex [8];
        int pops;
        int guard;

        t1_in = '{42, 17, 93, 25, 51, 38, 64, 70};
        t1_ex = '{93, 70, 64, 51, 42, 38, 25, 17};
        t2_in = '{290, 255, 256, 270, 260, 258, 257, 300};
        t2_ex = '{300, 290, 270, 260, 258, 257, 256, 255};
        t3_in = '{50, 30, 50, 0, 0, 0, 0, 0};
        t3_ex = '{50, 50, 30, 0, 0, 0, 0, 0};
        t4_in = '{0, 255, 128, 64, 192, 32, 224, 16};
        t4_ex = '{255, 224, 192, 128, 64, 32, 16, 0};
        t5_in = '{10, 20, 0, 0, 0, 0, 0, 0};
        t5_ex = '{20, 10, 0, 0, 0, 0, 0, 0};
        t6_in = '{42, 17, 93, 25, 0, 0, 0, 0};
        t6_ex = '{93, 42, 25, 17, 0, 0, 0, 0};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", W'(s_ready), W'(0));
        check("rst_m_valid", W'(m_valid), W'(0));
        check("rst_m_data", m_data, W'(0));
        check("rst_m_last", W'(m_last), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_s_ready", W'(s_ready), W'(1));
        check("post_rst_m_valid", W'(m_valid), W'(0));

        // Random block with explicit last
        expect_block(t1_ex, 8);
        send_block(t1_in, 8, 1'b1);
        wait_drain();

        // Implicit close on the eighth word
        expect_block(t2_ex, 8);
        send_block(t2_in, 8, 1'b0);
        wait_drain();

        // Short block with duplicates
        expect_block(t3_ex, 3);
        send_block(t3_in, 3, 1'b1);
        wait_drain();

        // Backpressure during drain
        toggle_mode = 1'b1;
        expect_block(t4_ex, 8);
        send_block(t4_in, 8, 1'b1);
        wait_drain();
        toggle_mode = 1'b0;

        // Reset after three outputs
        expect_block(t1_ex, 8);
        send_block(t1_in, 8, 1'b1);
        pops  = 1;
        guard = 0;
        while (pops < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (m_valid && m_ready) pops++;
        end
        if (pops < 3) fail_now("mid_drain_wait");
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_m_valid", W'(m_valid), W'(0));
        check("mid_rst_m_last", W'(m_last), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_rst_no_output", W'(m_valid), W'(0));
        expect_block(t5_ex, 2);
        send_block(t5_in, 2, 1'b1);
        wait_drain();

        // Four-word block (order flips in ascending builds)
        expect_block(t6_ex, 4);
        send_block(t6_in, 4, 1'b1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
